// File: rtl/error_sampler_pkg.sv
// error_sampler_pkg
//   Shared types and constants for the error sampler front end.
//   - state_t        : sampler FSM encoding
//   - N1_DEF         : default error word width
//   - sat_max_of/min : signed saturation limits for an n-bit word
package error_sampler_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CALC,
      S_STP,
      S_BUSY
   } state_t;

   localparam int N1_DEF = 16;

   function automatic int sat_max_of(input int n);
      return (32'sd1 <<< (n - 1)) - 32'sd1;
   endfunction

   function automatic int sat_min_of(input int n);
      return -(32'sd1 <<< (n - 1));
   endfunction

endpackage

// File: rtl/error_sampler_if.sv
// error_sampler_if
//   Handshake bundle between the sampler, the ADC front end and the PD filter.
//   adc_req : conversion start pulse (sampler -> ADC)
//   adc_vld : conversion result valid pulse (ADC -> sampler)
//   adc_dat : conversion result (ADC -> sampler)
//   e_k     : scaled loop error (sampler -> filter)
//   stp     : filter start pulse (sampler -> filter)
//   eop     : filter end-of-processing pulse (filter -> sampler)
//   modport master : sampler side; modport slave : ADC/filter side
interface error_sampler_if #(
   parameter int NA = 12,
   parameter int N1 = 16
);
   logic          adc_req;
   logic          adc_vld;
   logic [NA-1:0] adc_dat;
   logic [N1-1:0] e_k;
   logic          stp;
   logic          eop;

   modport master (
      output adc_req,
      input  adc_vld,
      input  adc_dat,
      output e_k,
      output stp,
      input  eop
   );

   modport slave (
      input  adc_req,
      output adc_vld,
      output adc_dat,
      input  e_k,
      input  stp,
      output eop
   );
endinterface

// File: rtl/error_sampler_sample_timer.sv
// sample_timer
//   Sample-period down-counter. Ticks when enabled and the count has
//   reached zero, then reloads with per (period minus one). Holding en
//   low parks the count at zero so the first enabled cycle ticks.
//   clk  : clock            rst : async active-low reset
//   en   : enable           per : period minus one
//   tick : sample instant
module sample_timer #(
   parameter int NT = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [NT-1:0] per,
   output logic          tick
);
   logic [NT-1:0] count;

   assign tick = en && (count == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (!en) begin
         count <= '0;
      end else if (tick) begin
         count <= per;
      end else begin
         count <= count - NT'(1);
      end
   end
endmodule

// File: rtl/error_sampler.sv
// error_sampler
//   Front end of the control loop: times the sample instant, requests an
//   ADC conversion, forms e_k = sat((ref - y) << SH) and hands it to the PD
//   filter with a stp pulse. e_k is held until the next sample's CALC.
//   A tick that arrives while a sample is still in flight sets sticky ovr.
//   Ports:
//     clk, rst (async active-low), en, per (period - 1), ref_val (setpoint),
//     ovr (sticky overrun), ovr_clr, bus (error_sampler_if.master)
//   Build option:
//     ERROR_SAT_EN defined   -> e_k saturates to the N1-bit signed range
//     ERROR_SAT_EN undefined -> e_k wraps (low N1 bits), no comparators
//
//   state  | meaning
//   -------+-----------------------------------------------
//   IDLE   | waiting for the sample tick
//   REQ    | adc_req pulse
//   WAIT   | waiting for adc_vld, capture y
//   CALC   | load e_k with the scaled error
//   STP    | stp pulse to the filter
//   BUSY   | filter running, waiting for eop
module error_sampler
   import error_sampler_pkg::*;
#(
   parameter int NA = 12,
   parameter int N1 = N1_DEF,
   parameter int SH = 4,
   parameter int NT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            en,
   input  logic [NT-1:0]   per,
   input  logic [NA-1:0]   ref_val,
   output logic            ovr,
   input  logic            ovr_clr,
   error_sampler_if.master bus
);
   state_t               state;
   state_t               state_nxt;
   logic                 tick;
   logic                 ovr_set;
   logic                 adc_req_c;
   logic                 stp_c;
   logic [NA-1:0]        y;
   logic signed [NA:0]   d;
   logic signed [N1-1:0] e_calc;
   logic signed [N1-1:0] e_k_q;

   sample_timer #(.NT(NT)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .per  (per),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      adc_req_c = 1'b0;
      stp_c     = 1'b0;
      ovr_set   = 1'b0;
      case (state)
         S_IDLE: begin
            if (tick) state_nxt = S_REQ;
         end
         S_REQ: begin
            adc_req_c = 1'b1;
            ovr_set   = tick;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            ovr_set = tick;
            if (bus.adc_vld) state_nxt = S_CALC;
         end
         S_CALC: begin
            ovr_set   = tick;
            state_nxt = S_STP;
         end
         S_STP: begin
            stp_c     = 1'b1;
            ovr_set   = tick;
            state_nxt = S_BUSY;
         end
         S_BUSY: begin
            // eop and tick together starts the next sample back to back
            if (bus.eop) begin
               state_nxt = tick ? S_REQ : S_IDLE;
            end else begin
               ovr_set = tick;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.adc_req = adc_req_c;
   assign bus.stp     = stp_c;
   assign bus.e_k     = e_k_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         y <= '0;
      end else if ((state == S_WAIT) && bus.adc_vld) begin
         y <= bus.adc_dat;
      end
   end

   assign d = $signed({1'b0, ref_val}) - $signed({1'b0, y});

`ifdef ERROR_SAT_EN
   localparam int SW = NA + 1 + SH;
   generate
      if (SW > N1) begin : g_sat
         localparam logic signed [SW-1:0] S_MAX = SW'(sat_max_of(N1));
         localparam logic signed [SW-1:0] S_MIN = SW'(sat_min_of(N1));
         localparam logic signed [N1-1:0] E_MAX = N1'(sat_max_of(N1));
         localparam logic signed [N1-1:0] E_MIN = N1'(sat_min_of(N1));
         logic signed [SW-1:0] s;
         assign s      = SW'(d) <<< SH;
         assign e_calc = (s > S_MAX) ? E_MAX :
                         (s < S_MIN) ? E_MIN : N1'(s);
      end else begin : g_fits
         // the full shifted range fits in N1, so saturation is unreachable
         assign e_calc = N1'(d) <<< SH;
      end
   endgenerate
`else
   assign e_calc = N1'(d) <<< SH;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_k_q <= '0;
      end else if (state == S_CALC) begin
         e_k_q <= e_calc;
      end
   end

   // set beats clear so a concurrent overrun is never lost
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovr <= 1'b0;
      end else if (ovr_set) begin
         ovr <= 1'b1;
      end else if (ovr_clr) begin
         ovr <= 1'b0;
      end
   end
endmodule

// File: tb/tb_error_sampler.sv
// tb_error_sampler
//   Directed bench for error_sampler with an event-scheduled reference model
//   checked every cycle, plus hand-computed literal checks.
module tb_error_sampler;
   localparam int NA = 12;
   localparam int N1 = 16;
   localparam int SH = 4;
   localparam int NT = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          en = 1'b0;
   logic [NT-1:0] per = 16'd30;
   logic [NA-1:0] ref_val = '0;
   logic          ovr;
   logic          ovr_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   error_sampler_if #(.NA(NA), .N1(N1)) bus ();

   error_sampler #(.NA(NA), .N1(N1), .SH(SH), .NT(NT)) dut (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .per     (per),
      .ref_val (ref_val),
      .ovr     (ovr),
      .ovr_clr (ovr_clr),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] exp_err(input int r, input int yv);
      int s;
      s = (r - yv) * (1 << SH);
`ifdef ERROR_SAT_EN
      if (s > 32767) s = 32767;
      else if (s < -32768) s = -32768;
`endif
      return s[15:0];
   endfunction

   // ---------------- reference model (event schedule per sample) -------------
   int          cyc_m = 0;
   bit          m_was_en = 0;
   bit          m_busy = 0;
   bit          m_got_vld = 0;
   bit          m_ovr = 0;
   int          m_last_tick = 0;
   int          m_per = 0;
   int          m_req_cyc = 0;
   int          m_vld_cyc = 0;
   int          m_stp_cyc = 0;
   int          m_y = 0;
   logic [15:0] m_ek = '0;
   logic [15:0] m_pend = '0;

   always @(negedge clk) begin
      bit m_tick;
      bit e_req;
      bit e_stp;
      bit m_set;
      m_tick = 1'b0;
      m_set  = 1'b0;
      if (!rst) begin
         m_was_en  = 0;
         m_busy    = 0;
         m_got_vld = 0;
         m_ovr     = 0;
         m_ek      = '0;
         m_y       = 0;
      end else begin
         m_tick = en && (!m_was_en || (cyc_m - m_last_tick == m_per + 1));
         if (m_busy && m_got_vld && cyc_m == m_stp_cyc) m_ek = m_pend;
      end
      e_req = rst && m_busy && (cyc_m == m_req_cyc);
      e_stp = rst && m_busy && m_got_vld && (cyc_m == m_stp_cyc);
      check("model_adc_req", bus.adc_req, e_req);
      check("model_stp", bus.stp, e_stp);
      check("model_e_k", bus.e_k, m_ek);
      check("model_ovr", ovr, m_ovr);
      if (rst) begin
         if (m_busy && m_got_vld && cyc_m == m_vld_cyc + 1)
            m_pend = exp_err(int'(ref_val), m_y);
         if (m_busy && !m_got_vld && cyc_m > m_req_cyc && bus.adc_vld) begin
            m_got_vld = 1;
            m_vld_cyc = cyc_m;
            m_stp_cyc = cyc_m + 2;
            m_y       = int'(bus.adc_dat);
         end
         if (m_busy && m_got_vld && cyc_m > m_stp_cyc && bus.eop) begin
            m_busy = 0;
            if (m_tick) begin
               m_busy = 1; m_got_vld = 0; m_req_cyc = cyc_m + 1;
            end
         end else if (m_tick) begin
            if (m_busy) m_set = 1;
            else begin
               m_busy = 1; m_got_vld = 0; m_req_cyc = cyc_m + 1;
            end
         end
         if (m_set) m_ovr = 1;
         else if (ovr_clr) m_ovr = 0;
         if (m_tick) begin
            m_last_tick = cyc_m;
            m_per       = int'(per);
         end
         m_was_en = en;
      end
      cyc_m++;
   end

   // ---------------- stimulus -------------------------------------------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_req(input int budget);
      bit ok;
      ok = 0;
      for (int i = 0; i < budget; i++) begin
         if (bus.adc_req) begin
            ok = 1;
            break;
         end
         step(1);
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL wait_req: no adc_req within %0d cycles, expected one", budget);
      end
   endtask

   // Called in a REQ cycle: answers one cycle later, checks e_k while eop is
   // withheld for 'hold' cycles after stp, then returns eop.
   task automatic run_sample(input string name, input logic [11:0] dat, input int hold,
                             input logic [15:0] exp_ek);
      int k;
      step(1);
      bus.adc_vld = 1'b1;
      bus.adc_dat = dat;
      step(1);
      bus.adc_vld = 1'b0;
      k = 2;
      while (!bus.stp && k < 20) begin
         step(1);
         k++;
      end
      check({name, "_tick_to_stp"}, k + 1, 4);
      check({name, "_e_k"}, bus.e_k, exp_ek);
      for (int i = 0; i < hold; i++) begin
         step(1);
         check({name, "_e_k_held"}, bus.e_k, exp_ek);
      end
      bus.eop = 1'b1;
      step(1);
      bus.eop = 1'b0;
   endtask

   initial begin
      int first_ovr;
      int extra_req;
      int n_stp;
      int n_req;
      bus.adc_vld = 1'b0;
      bus.adc_dat = '0;
      bus.eop     = 1'b0;

      step(3);
      check("rst_e_k", bus.e_k, 16'h0000);
      check("rst_stp", bus.stp, 1'b0);
      check("rst_adc_req", bus.adc_req, 1'b0);
      check("rst_ovr", ovr, 1'b0);

      // basic sample: 2048 - 1024 = 1024, << 4 = 0x4000
      rst = 1'b1; ref_val = 12'd2048; per = 16'd30; en = 1'b1;
      step(1);
      check("first_tick_req", bus.adc_req, 1'b1);
      run_sample("s1", 12'd1024, 4, 16'h4000);

`ifdef ERROR_SAT_EN
      ref_val = 12'd4095; wait_req(40); run_sample("pos_full", 12'd0, 1, 16'h7FFF);
      ref_val = 12'd0;    wait_req(40); run_sample("neg_full", 12'd4095, 1, 16'h8000);
`else
      ref_val = 12'd4095; wait_req(40); run_sample("pos_full", 12'd0, 1, 16'hFFF0);
      ref_val = 12'd0;    wait_req(40); run_sample("neg_full", 12'd4095, 1, 16'h0010);
`endif

      // overrun: per=7, eop withheld; ticks land at R+7, R+15, R+23
      en = 1'b0; step(2); per = 16'd7; en = 1'b1; step(1);
      check("ovr_req", bus.adc_req, 1'b1);
      first_ovr = -1; extra_req = 0;
      for (int k = 1; k <= 22; k++) begin
         step(1);
         bus.adc_vld = (k == 1);
         bus.adc_dat = 12'd100;
         ovr_clr     = (k == 15 || k == 17);
         bus.eop     = (k == 20);
         if (k == 21) en = 1'b0;
         if (k >= 2 && k <= 19 && bus.adc_req) extra_req++;
         if (first_ovr < 0 && ovr) first_ovr = k;
         if (k == 16) check("ovr_set_wins", ovr, 1'b1);
         if (k == 18) check("ovr_clr", ovr, 1'b0);
      end
      check("ovr_first_cycle", first_ovr, 8);
      check("ovr_no_extra_req", extra_req, 0);

      // eop coincident with tick in BUSY (tick at R+7)
      ref_val = 12'd3000;
      step(2); en = 1'b1; step(1);
      for (int k = 1; k <= 14; k++) begin
         step(1);
         bus.adc_vld = (k == 1 || k == 9);
         bus.adc_dat = 12'd2000;
         bus.eop     = (k == 7 || k == 13);
         if (k == 13) en = 1'b0;
         if (k == 8) begin
            check("eop_tick_req", bus.adc_req, 1'b1);
            check("eop_tick_no_ovr", ovr, 1'b0);
         end
      end
      check("eop_tick_e_k", bus.e_k, 16'd16000);

      // async reset while in WAIT
      per = 16'd30; en = 1'b1; step(1);
      step(2);
      rst = 1'b0;
      #1;
      check("rst_mid_e_k", bus.e_k, 16'h0000);
      check("rst_mid_req", bus.adc_req, 1'b0);
      check("rst_mid_stp", bus.stp, 1'b0);
      step(2);
      rst = 1'b1; bus.adc_vld = 1'b1; bus.adc_dat = 12'd5;
      step(1);
      bus.adc_vld = 1'b0;
      check("post_rst_first_tick", bus.adc_req, 1'b1);
      n_stp = 0;
      for (int k = 0; k < 6; k++) begin
         step(1);
         if (bus.stp) n_stp++;
      end
      check("late_vld_no_stp", n_stp, 0);
      bus.adc_vld = 1'b1; bus.adc_dat = 12'd2500;
      step(1);
      bus.adc_vld = 1'b0;
      step(2);
      check("post_rst_e_k", bus.e_k, 16'h1F40);
      step(1); bus.eop = 1'b1; step(1); bus.eop = 1'b0;

      // stray adc_vld in IDLE/BUSY, en dropped during WAIT
      bus.adc_vld = 1'b1; bus.adc_dat = 12'd7; step(1); bus.adc_vld = 1'b0;
      wait_req(40);
      n_stp = 0; n_req = 0;
      for (int k = 1; k <= 29; k++) begin
         step(1);
         if (k == 1) en = 1'b0;
         bus.adc_vld = (k == 2 || k == 5 || k == 9);
         bus.adc_dat = (k == 2) ? 12'd1000 : ((k == 5) ? 12'd0 : 12'd7);
         bus.eop     = (k == 7);
         if (bus.stp) n_stp++;
         if (bus.adc_req) n_req++;
         if (k == 4) check("en_drop_stp_cycle", bus.stp, 1'b1);
      end
      check("en_drop_one_stp", n_stp, 1);
      check("en_drop_no_req", n_req, 0);
      check("en_drop_e_k", bus.e_k, 16'h7D00);

      step(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected $finish", $time);
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/error_sampler.md
# error_sampler

Front-end stage of the control loop. Generates the periodic sample instant and requests a conversion from the ADC interface. Computes the scaled, saturated loop error `e_k = (ref − y) << SH` and hands it to the PD filter with a one-cycle `stp` pulse. It holds `e_k` stable until the filter returns `eop`, and flags sample overruns when the filter cannot keep up with the sample period.

## Interface
Parameters:
- `NA`, 12, ADC sample and reference width (unsigned)
- `N1`, 16, error output width (signed, two's complement); matches the filter's error width
- `SH`, 4, left-shift gain applied to the raw difference
- `NT`, 16, sample-period counter width

Ports:
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-low reset
- `en` in 1 — sampling enable
- `per` in NT — sample period in clock cycles, minus 1
- `ref` in NA — setpoint
- `adc_req` out 1 — conversion start, one-cycle pulse
- `adc_vld` in 1 — conversion result valid, one-cycle pulse
- `adc_dat` in NA — conversion result
- `e_k` out N1 — error word to the filter
- `stp` out 1 — filter start, one-cycle pulse
- `eop` in 1 — filter end-of-processing pulse
- `ovr` out 1 — sticky overrun flag
- `ovr_clr` in 1 — clears `ovr`

## Operation
- Reset values:
  - outputs `e_k`=0, `stp`=0, `adc_req`=0, `ovr`=0
  - internal: timer count=0, FSM=IDLE, captured sample `y`=0
- Timer:
  - `tick` = `en` && count==0; on `tick`, count<=`per`.
  - Else if `en`, count decrements.
  - If !`en`, count<=0, so enabling produces an immediate tick.
  - `per`=0 ticks every enabled cycle.
- FSM states:
  - IDLE: on `tick` → REQ.
  - REQ: `adc_req`=1 for this cycle only → WAIT.
  - WAIT: on `adc_vld`, `y`<=`adc_dat` → CALC. `adc_vld` outside WAIT is ignored.
  - CALC: `e_k` register loaded with the computed error → STP.
  - STP: `stp`=1 for this cycle only → BUSY.
  - BUSY: on `eop` → IDLE, or directly → REQ if `tick` occurs in the same cycle (not an overrun).
- Overrun:
  - A `tick` in any state other than IDLE, except the BUSY+`eop` case, sets `ovr` and is dropped.
  - `ovr_clr` clears `ovr`; if set and clear occur in the same cycle, set wins.
- Deasserting `en` mid-cycle does not abort; the current sample completes through BUSY→IDLE.
- `e_k` changes only in CALC and is held stable across STP, BUSY and IDLE.
- Arithmetic:
  - `d` = {0,`ref`} − {0,`y`}, NA+1 bits signed.
  - `s` = `d` sign-extended to NA+1+SH bits, then shifted left by SH.
  - `e_k` = `s` saturated to N1 signed: above 2^(N1−1)−1 → 0x7FF…F; below −2^(N1−1) → 0x800…0.
  - If NA+1+SH ≤ N1, `s` is sign-extended and never saturates.

## Timing
- `tick` in cycle t → `adc_req` in cycle t+1.
- `adc_vld` in cycle v → CALC in v+1. In v+2, `e_k` holds the new value and `stp`=1.
- Minimum tick-to-`stp` latency: 4 cycles (when `adc_vld` arrives in the cycle after `adc_req`).
- Minimum sample period for overrun-free operation: conversion latency + filter latency + 4 cycles.
- Asynchronous reset mid-operation:
  - aborts immediately; all outputs and state return to reset values
  - any pending `adc_vld`/`eop` after release is ignored (FSM is in IDLE)

## Configuration
- `ERROR_SAT_EN` defined: saturation as described above.
- Undefined: `e_k` = low N1 bits of `s` (two's-complement wrap), no comparators synthesized.

## Structure
- Package `error_sampler_pkg`:
  - FSM state enum (IDLE, REQ, WAIT, CALC, STP, BUSY)
  - localparam saturation limits derived from N1
- One sub-module `sample_timer` (`clk`, `rst`, `en`, `per`, `tick`) holding the period counter.
- FSM, capture, arithmetic and overrun logic live in the top level.

## Test plan
- NA=12, SH=4, N1=16; `ref`=2048, `adc_dat`=1024, `adc_vld` one cycle after `adc_req` → `e_k`=0x4000, `stp` exactly 4 cycles after `tick`; `e_k` held until `eop`.
- `ref`=4095, `adc_dat`=0 → `e_k`=0x7FFF with `ERROR_SAT_EN`, 0xFFF0 without. `ref`=0, `adc_dat`=4095 → 0x8000 with, 0x0010 without.
- `per`=7, `eop` withheld 20 cycles → `ovr`=1 at the first in-BUSY tick, no extra `adc_req`. Then `ovr_clr` with a concurrent overrun → `ovr` stays 1; a later clear alone → `ovr`=0.
- `eop` and `tick` coincident in BUSY → `adc_req` next cycle, `ovr` stays 0.
- `rst` low while in WAIT → all outputs 0 immediately. A late `adc_vld` after release → no `stp`. First `tick` on the first enabled cycle.
- `adc_vld` pulses during IDLE/BUSY and `en` dropped during WAIT → ignored vs. sample completing normally with one `stp`, then no further `adc_req`.
